dds_phase_gen: RTL and testbench
================================

DDS_PHASE_GEN -- requirements
Module: dds_phase_gen

Interface
REQ-001 The block SHALL have a parameter ACC_W, default 16, giving the phase accumulator width; it SHALL be at least 10.
REQ-002 The block SHALL have port clk, input, 1 bit: the system clock; every register SHALL be clocked on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port k, input, 8 bits: the frequency control word, zero-extended to ACC_W.
REQ-005 The block SHALL have port sw, input, 4 bits: one-hot waveform select; 0001 = sine, 0010 = square, 0100 = triangle, 1000 = sawtooth.
REQ-006 The block SHALL have port en, input, 1 bit: advance enable.
REQ-007 The block SHALL have port phase_clr, input, 1 bit: synchronous phase clear.
REQ-008 The block SHALL have port spo_in, input, 8 bits: the waveform ROM data, combinational from addr.
REQ-009 The block SHALL have port addr, output, 10 bits: the waveform ROM address.
REQ-010 The block SHALL have port dac_data, output, 8 bits: the registered sample to the DAC and display.
REQ-011 The block SHALL have port wrap, output, 1 bit: a one-cycle pulse at each phase cycle.

Function
REQ-012 The block SHALL keep these registers: acc[ACC_W-1:0], k_act[7:0], sel_act[1:0], dac_data, wrap.
REQ-013 sel_act SHALL encode the waveform as sine = 00, square = 01, triangle = 10, sawtooth = 11.
REQ-014 addr SHALL be combinational and equal {sel_act, acc[ACC_W-1:ACC_W-8]}, i.e. 4 tables of 256 entries.
REQ-015 Sum: the block SHALL form {carry, sum} = acc + k_act, ACC_W+1 bits wide; carry is the wrap event.
REQ-016 Advance: when en=1 and phase_clr=0, acc SHALL take sum; acc wraps modulo 2^ACC_W, with no saturation.
REQ-017 Hold: when en=0 and phase_clr=0, acc, dac_data and wrap SHALL hold, except that wrap SHALL be 0.
REQ-018 Clear: phase_clr=1 SHALL set acc to 0 and force a reload, regardless of en; phase_clr SHALL take priority over carry.
REQ-019 Reload condition: the block SHALL reload in any cycle where (en=1 and carry=1) or phase_clr=1 or k_act=0.
REQ-020 On reload, k_act SHALL take k.
REQ-021 On reload, sel_act SHALL take the decode of sw; if sw is not one-hot, sel_act SHALL hold its value.
REQ-022 Outside a reload, changes on k and sw SHALL have no effect; frequency and waveform change only at phase boundaries, so no glitches occur.
REQ-023 dac_data SHALL take spo_in on every cycle with en=1; latency from an acc update to the corresponding dac_data is 1 clk.
REQ-024 wrap SHALL be 1 for exactly the one cycle after a cycle with en=1, carry=1 and phase_clr=0, and 0 otherwise.
REQ-025 Boundary, k=0 at reload: k_act stays 0 and the reload repeats every cycle, so acc holds; a nonzero k is picked up within 1 clk.
REQ-026 Boundary, carry and phase_clr in the same cycle: acc SHALL become 0 and wrap SHALL become 0.
REQ-027 Boundary, k=255: the block SHALL run normally; the output frequency is k*f_clk/2^ACC_W.

Reset
REQ-028 While rst=1, acc, k_act and dac_data SHALL be 0, sel_act SHALL be 00, and wrap SHALL be 0; addr therefore reads 0.
REQ-029 Assertion of rst SHALL act immediately, without waiting for a clock edge; deassertion SHALL take effect at the next rising clk edge.
REQ-030 Reset mid-cycle SHALL discard the phase; after release, k and sw are loaded on the first clk because k_act = 0.

Verification
REQ-031 Reset, then k=1, sw=1000, en=1 → cycle 1 loads k_act=1 with acc=0; acc then increments by 1 per clk; addr[7:0] increments every 256 clks; addr[9:8]=11.
REQ-032 k=1, ACC_W=16 → first wrap pulse at exactly 2^16 clks after the load; the period then repeats at 65536 clks.
REQ-033 Change k from 1 to 8 mid-cycle → the step stays 1 until the wrap; the step becomes 8 after it; the next period is 8192 clks.
REQ-034 Change sw from 0001 to 0100 mid-cycle, then to 0011 → addr[9:8] stays 00 until the wrap, then becomes 10; the invalid 0011 holds 10.
REQ-035 Assert phase_clr in the same cycle the carry occurs, with en=1 → acc=0, wrap stays 0, and k and sw are reloaded.
REQ-036 Drive spo_in = addr[7:0] as a ROM stub, toggle en, and assert rst asynchronously between clk edges → dac_data lags addr by 1 clk and freezes while en=0; rst zeroes all outputs immediately.

Source files
------------

// File: rtl/dds_phase_gen.sv
// dds_phase_gen: phase accumulator for a DDS waveform generator driving an
// external 4 x 256 waveform ROM.
//
// The frequency word and waveform select are only sampled at phase
// boundaries (a reload), so the output never glitches mid-period.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   k         in   8-bit frequency control word (zero-extended to ACC_W)
//   sw        in   one-hot waveform select: 0001 sine, 0010 square,
//                  0100 triangle, 1000 sawtooth
//   en        in   advance enable
//   phase_clr in   synchronous phase clear (forces a reload)
//   spo_in    in   ROM data, combinational from addr
//   addr      out  ROM address {waveform, phase[ACC_W-1 -: 8]}
//   dac_data  out  registered sample
//   wrap      out  one-cycle pulse per phase cycle
module dds_phase_gen #(
  parameter int unsigned ACC_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] k,
  input  logic [3:0] sw,
  input  logic       en,
  input  logic       phase_clr,
  input  logic [7:0] spo_in,
  output logic [9:0] addr,
  output logic [7:0] dac_data,
  output logic       wrap
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       k_act_q, k_act_d;
  logic [1:0]       sel_act_q, sel_act_d;
  logic [7:0]       dac_data_q, dac_data_d;
  logic             wrap_q, wrap_d;

  logic [ACC_W:0]   sum;
  logic             carry;
  logic             reload;
  logic             sw_valid;
  logic [1:0]       sw_sel;

  assign sum   = {1'b0, acc_q} + (ACC_W + 1)'(k_act_q);
  assign carry = sum[ACC_W];

  // k_act == 0 keeps reloading every cycle so a fresh nonzero k (e.g. right
  // after reset) is picked up without waiting for a wrap that never comes.
  assign reload = (en & carry) | phase_clr | (k_act_q == 8'd0);

  always_comb begin
    sw_valid = 1'b1;
    sw_sel   = 2'b00;
    unique case (sw)
      4'b0001: sw_sel = 2'b00;
      4'b0010: sw_sel = 2'b01;
      4'b0100: sw_sel = 2'b10;
      4'b1000: sw_sel = 2'b11;
      default: sw_valid = 1'b0;
    endcase
  end

  always_comb begin
    acc_d      = acc_q;
    k_act_d    = k_act_q;
    sel_act_d  = sel_act_q;
    dac_data_d = dac_data_q;
    // Clear wins over the carry: no wrap pulse for a cleared period.
    wrap_d     = en & carry & ~phase_clr;

    if (phase_clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sum[ACC_W-1:0];
    end

    if (en) begin
      dac_data_d = spo_in;
    end

    if (reload) begin
      k_act_d = k;
      if (sw_valid) begin
        sel_act_d = sw_sel;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      k_act_q    <= '0;
      sel_act_q  <= 2'b00;
      dac_data_q <= '0;
      wrap_q     <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      k_act_q    <= k_act_d;
      sel_act_q  <= sel_act_d;
      dac_data_q <= dac_data_d;
      wrap_q     <= wrap_d;
    end
  end

  assign addr     = {sel_act_q, acc_q[ACC_W-1 -: 8]};
  assign dac_data = dac_data_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_dds_phase_gen.sv
// Testbench for dds_phase_gen (ACC_W = 16) with a ROM stub spo_in = addr[7:0].
module tb_dds_phase_gen;

  localparam int unsigned ACC_W = 16;

  logic       clk;
  logic       rst;
  logic [7:0] k;
  logic [3:0] sw;
  logic       en;
  logic       phase_clr;
  logic [7:0] spo_in;
  logic [9:0] addr;
  logic [7:0] dac_data;
  logic       wrap;

  dds_phase_gen #(
    .ACC_W(ACC_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .k        (k),
    .sw       (sw),
    .en       (en),
    .phase_clr(phase_clr),
    .spo_in   (spo_in),
    .addr     (addr),
    .dac_data (dac_data),
    .wrap     (wrap)
  );

  assign spo_in = addr[7:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  logic [15:0] m_acc;
  logic [7:0]  m_k;
  logic [1:0]  m_sel;
  logic [7:0]  m_dac;
  logic        m_wrap;

  // Expected {addr, dac_data, wrap} per clock
  logic [18:0] sb_q[$];

  typedef struct {
    logic [7:0] k;
    logic [3:0] sw;
    bit         en;
    bit         clr;
    int         reps;
    logic [9:0] exp_addr;
    bit         exp_wrap;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_acc  = '0;
    m_k    = '0;
    m_sel  = 2'b00;
    m_dac  = '0;
    m_wrap = 1'b0;
  endtask

  // One clock: drive inputs, predict, wait for the edge, compare.
  task automatic step(input logic [7:0] kk, input logic [3:0] ss, input bit ee, input bit cc);
    logic [16:0] s;
    logic        rl;
    logic [18:0] e;
    k = kk; sw = ss; en = ee; phase_clr = cc;
    s  = {1'b0, m_acc} + {9'b0, m_k};
    rl = (ee && s[16]) || cc || (m_k == 8'd0);
    m_wrap = ee && s[16] && !cc;
    if (ee) m_dac = m_acc[15:8];
    if (rl) begin
      m_k = kk;
      case (ss)
        4'b0001: m_sel = 2'b00;
        4'b0010: m_sel = 2'b01;
        4'b0100: m_sel = 2'b10;
        4'b1000: m_sel = 2'b11;
        default: ;
      endcase
    end
    if (cc) m_acc = '0;
    else if (ee) m_acc = s[15:0];
    sb_q.push_back({m_sel, m_acc[15:8], m_dac, m_wrap});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("scoreboard {addr,dac,wrap}", 32'({addr, dac_data, wrap}), 32'(e));
  endtask

  task automatic count_to_wrap(input logic [7:0] kk, input int exp_n, input string name);
    int n;
    n = 0;
    do begin
      step(kk, 4'b0001, 1'b1, 1'b0);
      n++;
    end while (wrap !== 1'b1 && n < 70000);
    check(name, 32'(n), 32'(exp_n));
  endtask

  initial begin
    //        k      sw       en  clr reps exp_addr wrap
    vecs[0]  = '{8'd1,   4'b1000, 1, 0, 1,   10'h300, 0};
    vecs[1]  = '{8'd1,   4'b1000, 1, 0, 255, 10'h300, 0};
    vecs[2]  = '{8'd1,   4'b1000, 1, 0, 1,   10'h301, 0};
    vecs[3]  = '{8'd1,   4'b1000, 0, 0, 5,   10'h301, 0};  // hold
    vecs[4]  = '{8'd255, 4'b0001, 1, 0, 256, 10'h302, 0};  // k/sw ignored mid-period
    vecs[5]  = '{8'd255, 4'b0010, 1, 1, 1,   10'h100, 0};  // clear reloads
    vecs[6]  = '{8'd0,   4'b0100, 1, 0, 257, 10'h1FF, 0};  // k=255 runs to 65535
    vecs[7]  = '{8'd0,   4'b0100, 1, 0, 1,   10'h200, 1};  // wrap, reload k=0
    vecs[8]  = '{8'd5,   4'b0011, 1, 0, 1,   10'h200, 0};  // k_act=0 reload, bad sw holds
    vecs[9]  = '{8'd5,   4'b0011, 1, 0, 2,   10'h201, 0};
    vecs[10] = '{8'd255, 4'b1000, 1, 1, 1,   10'h300, 0};
    vecs[11] = '{8'd0,   4'b0000, 1, 0, 257, 10'h3FF, 0};
    vecs[12] = '{8'd16,  4'b0010, 1, 1, 1,   10'h100, 0};  // clear on carry cycle
    vecs[13] = '{8'd0,   4'b0000, 1, 0, 16,  10'h101, 0};

    k = '0; sw = 4'b0001; en = 1'b0; phase_clr = 1'b0;
    rst = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    #1;
    check("reset addr", 32'(addr), 32'h0);
    check("reset dac_data", 32'(dac_data), 32'h0);
    check("reset wrap", 32'(wrap), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      for (int r = 0; r < vecs[i].reps; r++) step(vecs[i].k, vecs[i].sw, vecs[i].en, vecs[i].clr);
      check($sformatf("vec%0d addr", i), 32'(addr), 32'(vecs[i].exp_addr));
      check($sformatf("vec%0d wrap", i), 32'(wrap), 32'(vecs[i].exp_wrap));
    end

    // Frequency change mid-period takes effect only after the wrap.
    step(8'd200, 4'b0001, 1'b1, 1'b1);
    check("clr k=200 addr", 32'(addr), 32'h000);
    count_to_wrap(8'd8, 328, "first period k=200");
    check("post-wrap addr", 32'(addr), 32'h000);
    count_to_wrap(8'd8, 8184, "second period k=8 from residue 64");
    count_to_wrap(8'd8, 8192, "full period k=8");
    step(8'd8, 4'b0001, 1'b1, 1'b0);
    check("wrap single cycle", 32'(wrap), 32'h0);

    // Asynchronous reset between edges.
    step(8'd255, 4'b0001, 1'b1, 1'b1);
    for (int i = 0; i < 200; i++) step(8'd255, 4'b0001, 1'b1, 1'b0);
    check("pre-reset addr", 32'(addr), 32'h0C7);
    #2 rst = 1'b1;
    #1;
    check("async reset addr", 32'(addr), 32'h0);
    check("async reset dac_data", 32'(dac_data), 32'h0);
    check("async reset wrap", 32'(wrap), 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    step(8'd3, 4'b0100, 1'b1, 1'b0);
    check("post-reset load addr", 32'(addr), 32'h200);
    for (int i = 0; i < 100; i++) step(8'd3, 4'b0100, 1'b1, 1'b0);
    check("post-reset run addr", 32'(addr), 32'h201);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
